// File: rtl/mm_rom_loader_pkg.sv
// Shared modexp package: operand memory geometry,
// segment indices and loader state encoding.
package mm_rom_loader_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_SEG_WORDS = 64;
  localparam int LEN_W         = 7;

  localparam logic [1:0] SEG_A       = 2'd0;
  localparam logic [1:0] SEG_B       = 2'd1;
  localparam logic [1:0] SEG_N       = 2'd2;
  localparam logic [1:0] SEG_SCRATCH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mm_rom_loader.sv
// Streams len words into one operand segment, then
// zero-pads the remainder of the segment.
import mm_rom_loader_pkg::*;

module mm_rom_loader #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SEG_WORDS = DEF_SEG_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        seg_sel,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W-1:0] SEG_LEN = LEN_W'(SEG_WORDS);
  localparam logic [LEN_W-1:0] LAST    = LEN_W'(SEG_WORDS - 1);

  state_t            state, state_n;
  logic [1:0]        seg_q, seg_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  idx, idx_n, idx_inc;
  logic [ADDR_W-1:0] addr_n, wr_addr;
  logic [DATA_W-1:0] din_n;
  logic              we_n, done_n, err_n;
  logic              len_ok;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign len_ok   = (len != '0) && (len <= SEG_LEN);
  assign idx_inc  = idx + LEN_W'(1);
  assign wr_addr  = ADDR_W'(seg_q) * ADDR_W'(SEG_WORDS)
                  + ADDR_W'(idx);

  always_comb begin
    state_n = state;
    seg_n   = seg_q;
    len_n   = len_q;
    idx_n   = idx;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    din_n   = mem_din;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (len_ok) begin
            state_n = S_LOAD;
            seg_n   = seg_sel;
            len_n   = len;
            idx_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        err_n = start;
        // abort drops a same-cycle word
        if (abort) begin
          state_n = S_IDLE;
        end else if (in_valid) begin
          we_n   = 1'b1;
          addr_n = wr_addr;
          din_n  = in_data;
          idx_n  = idx_inc;
          if (idx_inc == len_q)
            state_n = (len_q == SEG_LEN) ? S_FIN : S_PAD;
        end
      end
      S_PAD: begin
        err_n = start;
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = wr_addr;
          din_n  = '0;
          idx_n  = idx_inc;
          if (idx == LAST)
            state_n = S_FIN;
        end
      end
      S_FIN: begin
        err_n   = start;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      seg_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      seg_q    <= seg_n;
      len_q    <= len_n;
      idx      <= idx_n;
      mem_we   <= we_n;
      mem_addr <= addr_n;
      mem_din  <= din_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_mm_rom_loader.sv
// Directed bench for mm_rom_loader with a write-list
// model and a per-cycle compare process.
module tb_mm_rom_loader;

  localparam int SEGW = 64;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  seg_sel = '0;
  logic [6:0]  len = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        busy, done, err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  wr_t exp_q[$];
  int  wcount, done_cnt, err_cnt;
  int  first_cyc, last_cyc, done_cyc;
  int  first_addr, last_addr;

  mm_rom_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .seg_sel(seg_sel), .len(len), .abort(abort),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Model: a successful load writes the given words to
  // base+i, then zeros up to the end of the segment.
  task automatic model_load(input int seg,
                            input int n_words,
                            input logic [15:0] w[$],
                            input bit pad);
    wr_t e;
    for (int i = 0; i < (pad ? SEGW : n_words); i++) begin
      e.addr = 8'(seg * SEGW + i);
      e.data = (i < n_words) ? w[i] : 16'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic clr_stats();
    wcount = 0; done_cnt = 0; err_cnt = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    first_addr = -1; last_addr = -1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_addr, -1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_din, e.data);
        end
        if (first_cyc < 0) begin
          first_cyc  = cyc;
          first_addr = mem_addr;
        end
        last_cyc  = cyc;
        last_addr = mem_addr;
        wcount++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (in_ready && !busy) chk("ready_implies_busy", 0, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] s,
                          input logic [6:0] l);
    start = 1'b1; seg_sel = s; len = l;
    tick(1);
    start = 1'b0;
  endtask

  // Drive one word until accepted; optional start/abort
  // pulses ride on the first offered cycle.
  task automatic send(input logic [15:0] d,
                      input bit st, input bit ab);
    bit acc;
    int guard;
    in_valid = 1'b1; in_data = d;
    start = st; abort = ab;
    guard = 0;
    do begin
      acc = in_ready;
      tick(1);
      start = 1'b0; abort = 1'b0;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 300) begin
      tick(1);
      g++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    tick(3);
  endtask

  initial begin
    logic [15:0] w[$];

    clr_stats();
    #2;
    chk("rst_outputs",
        {mem_we, mem_addr, mem_din, in_ready, busy, done, err},
        0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Full segment, back-to-back words
    clr_stats();
    w.delete();
    for (int i = 1; i <= 64; i++) w.push_back(16'(i));
    model_load(1, 64, w, 1);
    do_start(2'd1, 7'd64);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 1);
    for (int i = 0; i < 64; i++) send(w[i], 0, 0);
    wait_idle();
    chk("t1_writes", wcount, 64);
    chk("t1_first_addr", first_addr, 64);
    chk("t1_last_addr", last_addr, 127);
    chk("t1_span", last_cyc - first_cyc, 63);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_time", done_cyc, last_cyc + 1);
    chk("t1_q_empty", exp_q.size(), 0);

    // Short load with gaps, zero padding
    clr_stats();
    w.delete();
    w.push_back(16'hAAAA);
    w.push_back(16'hBBBB);
    w.push_back(16'hCCCC);
    model_load(2, 3, w, 1);
    do_start(2'd2, 7'd3);
    for (int i = 0; i < 3; i++) begin
      send(w[i], 0, 0);
      tick(2);
    end
    wait_idle();
    chk("t2_writes", wcount, 64);
    chk("t2_first_addr", first_addr, 128);
    chk("t2_last_addr", last_addr, 191);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_time", done_cyc, last_cyc + 1);
    chk("t2_q_empty", exp_q.size(), 0);

    // Illegal lengths
    clr_stats();
    do_start(2'd0, 7'd0);
    chk("t3_busy0", busy, 0);
    tick(2);
    do_start(2'd0, 7'd65);
    chk("t3_busy65", busy, 0);
    tick(3);
    chk("t3_err_cnt", err_cnt, 2);
    chk("t3_writes", wcount, 0);

    // start+abort in IDLE: abort wins, no err
    clr_stats();
    start = 1'b1; abort = 1'b1; len = 7'd5;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t3b_busy", busy, 0);
    tick(3);
    chk("t3b_err", err_cnt, 0);

    // Abort on the 5th handshake
    clr_stats();
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back(16'h1000 + 16'(i));
    model_load(0, 4, w, 0);
    do_start(2'd0, 7'd10);
    for (int i = 0; i < 4; i++) send(w[i], 0, 0);
    send(w[4], 0, 1);
    chk("t4_busy_next", busy, 0);
    tick(5);
    chk("t4_writes", wcount, 4);
    chk("t4_last_addr", last_addr, 3);
    chk("t4_done", done_cnt, 0);
    chk("t4_q_empty", exp_q.size(), 0);

    // start while busy is ignored
    clr_stats();
    w.delete();
    for (int i = 0; i < 64; i++) w.push_back(16'h5A00 ^ 16'(i * 3));
    model_load(3, 64, w, 1);
    do_start(2'd3, 7'd64);
    len = 7'd2; seg_sel = 2'd0;
    for (int i = 0; i < 64; i++) send(w[i], i == 10, 0);
    wait_idle();
    chk("t5_err_cnt", err_cnt, 1);
    chk("t5_writes", wcount, 64);
    chk("t5_first_addr", first_addr, 192);
    chk("t5_last_addr", last_addr, 255);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_q_empty", exp_q.size(), 0);

    // Reset during padding
    clr_stats();
    w.delete();
    w.push_back(16'h1234);
    w.push_back(16'h5678);
    model_load(2, 2, w, 1);
    do_start(2'd2, 7'd2);
    send(w[0], 0, 0);
    send(w[1], 0, 0);
    tick(5);
    chk("t6_in_pad", {busy, in_ready}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs",
        {mem_we, mem_addr, mem_din, in_ready, busy, done, err},
        0);
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    clr_stats();
    tick(12);
    chk("t6_no_writes", wcount, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mm_rom_loader.md
MM_ROM_LOADER -- requirements
Module: mm_rom_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand word width.
REQ-002 SHALL have parameter ADDR_W, default 8, operand-memory address width.
REQ-003 SHALL have parameter SEG_WORDS, default 64, words per operand segment (4 segments fill 2^ADDR_W).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request, sampled in IDLE only.
REQ-007 SHALL have port seg_sel  input  2  target segment; base address = seg_sel*SEG_WORDS.
REQ-008 SHALL have port len  input  7  number of streamed words, legal range 1..SEG_WORDS.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current load.
REQ-010 SHALL have port in_valid  input  1  stream word valid.
REQ-011 SHALL have port in_data  input  DATA_W  stream word, least-significant word first.
REQ-012 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-013 SHALL have port mem_addr  output  ADDR_W  write address to the operand memory write port.
REQ-014 SHALL have port mem_din  output  DATA_W  write data to the operand memory.
REQ-015 SHALL have port mem_we  output  1  write enable to the operand memory.
REQ-016 SHALL have ports busy, done, err  output  1 each  busy = not IDLE; done/err = one-cycle pulses.

Function
REQ-017 SHALL implement states IDLE, LOAD, PAD, FIN.
REQ-018 IDLE: start with 1<=len<=SEG_WORDS SHALL latch seg_sel/len, clear word index to 0, go to LOAD next cycle.
REQ-019 IDLE: start with len=0 or len>SEG_WORDS SHALL pulse err next cycle, stay IDLE, no write.
REQ-020 LOAD: in_ready SHALL be 1; a handshake (in_valid&in_ready) at cycle t SHALL produce mem_we=1, mem_addr=base+index, mem_din=in_data at cycle t+1, index increments.
REQ-021 LOAD: no handshake SHALL produce mem_we=0 next cycle; index holds; stalls of any length are legal.
REQ-022 LOAD: handshake of the len-th word SHALL go to PAD if len<SEG_WORDS, else to FIN.
REQ-023 PAD: in_ready=0; one zero word per cycle SHALL be written at base+index for index len..SEG_WORDS-1, then go to FIN.
REQ-024 FIN: done SHALL be 1 for exactly the one cycle after the final mem_we cycle, then IDLE.
REQ-025 Exactly SEG_WORDS writes SHALL occur per successful load, addresses strictly ascending within one segment, never leaving it.
REQ-026 start while busy SHALL be ignored and SHALL pulse err next cycle; the current load continues unaffected.
REQ-027 abort in LOAD/PAD SHALL force IDLE next cycle, mem_we=0 from next cycle, no done; abort has priority over a same-cycle handshake (word dropped, not written).
REQ-028 abort in IDLE SHALL have no effect; simultaneous start and abort in IDLE: abort wins, start ignored, no err.
REQ-029 mem_addr/mem_din/mem_we/done/err SHALL be registered outputs; in_ready and busy SHALL decode directly from state.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, index 0, mem_we=0, mem_addr=0, mem_din=0, in_ready=0, busy=0, done=0, err=0.
REQ-031 Reset mid-load SHALL abandon the load with no further writes after rst_n deasserts.

Structure
REQ-032 State encoding, DATA_W/ADDR_W/SEG_WORDS defaults and segment-index constants (A=0, B=1, N=2, SCRATCH=3) SHALL live in a shared modexp package.
REQ-033 Block SHALL be single-module; no sub-module.

Verification
REQ-034 start, seg_sel=1, len=64, 64 back-to-back words 0x0001..0x0040 -> writes addr 64..127 data 0x0001..0x0040 on 64 consecutive cycles, done one cycle after addr 127.
REQ-035 start, seg_sel=2, len=3, words 0xAAAA,0xBBBB,0xCCCC with 2-cycle gaps -> writes addr 128..130 with those values, then 61 zero writes addr 131..191, one done.
REQ-036 start with len=0, then len=65 -> err pulse each time, busy stays 0, no mem_we.
REQ-037 seg_sel=0, len=10, abort on same cycle as 5th handshake -> exactly 4 writes addr 0..3, no done, busy=0 next cycle.
REQ-038 start during LOAD of seg_sel=3, len=64 -> single err pulse, load completes addr 192..255, one done.
REQ-039 rst_n low during PAD -> all outputs 0 immediately; after release no mem_we until a new start.
